// File: rtl/alu_seq_if.sv
// Bundle of the command, ALU, response and debug signals of alu_seq.
// slave: the sequencer itself; master: whatever drives commands and
// hosts the combinational ALU.
interface alu_seq_if #(
  parameter int BW = 16
);
  // command channel
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode;
  logic [1:0]    cmd_ra;
  logic [1:0]    cmd_rb;
  logic [1:0]    cmd_rd;
  logic          cmd_use_imm;
  logic [BW-1:0] cmd_imm;
  // external combinational ALU
  logic [BW-1:0] alu_a;
  logic [BW-1:0] alu_b;
  logic [3:0]    alu_op;
  logic [BW-1:0] alu_out;
  logic [2:0]    alu_flags;
  // response channel
  logic          rsp_valid;
  logic          rsp_ready;
  logic [BW-1:0] rsp_data;
  logic [2:0]    rsp_flags;
  logic [1:0]    rsp_rd;
  // status, counters and debug read port
  logic [2:0]    status;
  logic          clr_status;
  logic [15:0]   op_count;
  logic [1:0]    dbg_addr;
  logic [BW-1:0] dbg_data;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_ra, cmd_rb, cmd_rd, cmd_use_imm, cmd_imm,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_out, alu_flags,
    output rsp_valid, rsp_data, rsp_flags, rsp_rd,
    input  rsp_ready,
    output status, op_count, dbg_data,
    input  clr_status, dbg_addr
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_ra, cmd_rb, cmd_rd, cmd_use_imm, cmd_imm,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_out, alu_flags,
    input  rsp_valid, rsp_data, rsp_flags, rsp_rd,
    output rsp_ready,
    input  status, op_count, dbg_data,
    output clr_status, dbg_addr
  );
endinterface

// File: rtl/alu_seq.sv
// Sequencer around an external combinational ALU: a 4-entry register file
// feeds operands, the result is written back and offered as a response.
// One command in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
module alu_seq #(
  parameter int BW   = 16,
  parameter int NREG = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] regs_q [NREG];
  logic [BW-1:0] regs_d [NREG];
  logic [BW-1:0] alu_a_q, alu_a_d;
  logic [BW-1:0] alu_b_q, alu_b_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic [1:0]    rd_q, rd_d;
  logic [BW-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]    rsp_flags_q, rsp_flags_d;
  logic [2:0]    status_q, status_d;
  logic [15:0]   op_count_q, op_count_d;

  logic cmd_ready;
  logic rsp_valid;
  logic exec_en;
  logic accept;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: EXEC always lasts one cycle, RESP waits for the consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.cmd_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: commands only accepted in IDLE, response only offered in RESP
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    exec_en   = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready = 1'b1;
      S_EXEC:  exec_en   = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = cmd_ready && bus.cmd_valid;

  // Datapath next values: operand snapshot on accept, result capture in EXEC
  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    status_d    = bus.clr_status ? 3'b000 : status_q;
    op_count_d  = op_count_q;
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (accept) begin
      alu_a_d  = regs_q[bus.cmd_ra];
      alu_b_d  = bus.cmd_use_imm ? bus.cmd_imm : regs_q[bus.cmd_rb];
      alu_op_d = bus.cmd_opcode;
      rd_d     = bus.cmd_rd;
    end
    if (exec_en) begin
      rsp_data_d  = bus.alu_out;
      rsp_flags_d = bus.alu_flags;
      // clear is applied first so fresh flags survive a simultaneous clear
      status_d    = status_d | bus.alu_flags;
      op_count_d  = op_count_q + 16'd1;
      for (int i = 0; i < NREG; i++) begin
        if (rd_q == 2'(i)) regs_d[i] = bus.alu_out;
      end
    end
  end

  // Datapath registers, all cleared by reset so an aborted op leaves no trace
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      status_q    <= '0;
      op_count_q  <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      status_q    <= status_d;
      op_count_q  <= op_count_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Output wiring; rd is held from acceptance so it doubles as rsp_rd
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.rsp_rd    = rd_q;
  assign bus.status    = status_q;
  assign bus.op_count  = op_count_q;
  assign bus.dbg_data  = regs_q[bus.dbg_addr];

endmodule
